// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_sync_gen
// Description : 640x480@60 VGA raster timing (counters, sync, blank, strobes).
// Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_gen #(
  parameter int H_VISIBLE       = 640,
  parameter int H_FRONT         = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BACK          = 48,
  parameter int V_VISIBLE       = 480,
  parameter int V_FRONT         = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BACK          = 33,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  output logic       o_HSync,
  output logic       o_VSync,
  output logic       o_HBlank,
  output logic       o_VBlank,
  output logic       o_HReset,
  output logic       o_VReset,
  output logic [9:0] o_Col,
  output logic [9:0] o_Row
);

  localparam int   c_H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int   c_V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam logic c_SYNC_ON  = (SYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;

  localparam logic [9:0] c_H_LAST   = 10'(c_H_TOTAL - 1);
  localparam logic [9:0] c_V_LAST   = 10'(c_V_TOTAL - 1);
  localparam logic [9:0] c_HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] c_HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] c_VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] c_VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0] r_h, r_v;
  logic [9:0] w_h_next, w_v_next;
  logic       w_h_wrap;
  logic       w_hsync, w_vsync, w_hblank, w_vblank, w_hreset, w_vreset;

  // Decodes use next-state counters so the registered outputs line up with o_Col/o_Row.
  always_comb begin
    w_h_wrap = (r_h == c_H_LAST);
    w_h_next = w_h_wrap ? 10'd0 : r_h + 10'd1;
    w_v_next = r_v;
    if (w_h_wrap) begin
      w_v_next = (r_v == c_V_LAST) ? 10'd0 : r_v + 10'd1;
    end
    w_hblank = (w_h_next >= 10'(H_VISIBLE));
    w_vblank = (w_v_next >= 10'(V_VISIBLE));
    w_hsync  = ((w_h_next >= c_HS_START) && (w_h_next < c_HS_END)) ? c_SYNC_ON : ~c_SYNC_ON;
    w_vsync  = ((w_v_next >= c_VS_START) && (w_v_next < c_VS_END)) ? c_SYNC_ON : ~c_SYNC_ON;
    w_hreset = (w_h_next == c_H_LAST);
    w_vreset = (w_h_next == c_H_LAST) && (w_v_next == c_V_LAST);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_h      <= 10'd0;
      r_v      <= 10'd0;
      o_HSync  <= ~c_SYNC_ON;
      o_VSync  <= ~c_SYNC_ON;
      o_HBlank <= 1'b0;
      o_VBlank <= 1'b0;
      o_HReset <= 1'b0;
      o_VReset <= 1'b0;
    end else begin
      r_h      <= w_h_next;
      r_v      <= w_v_next;
      o_HSync  <= w_hsync;
      o_VSync  <= w_vsync;
      o_HBlank <= w_hblank;
      o_VBlank <= w_vblank;
      o_HReset <= w_hreset;
      o_VReset <= w_vreset;
    end
  end

  assign o_Col = r_h;
  assign o_Row = r_v;

endmodule
`default_nettype wire
